// File: rtl/pico_serial_reader_pkg.sv
// Shared definitions for the RP2040 three-wire host link receiver.
package pico_serial_reader_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int PICO_BYTE_BITS      = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/pico_serial_reader_sync_edge.sv
// Multi-flop synchronizer with a history flop and registered rise/fall detect.
// Edges are suppressed until the chain holds real pin samples, so a level that is already high at reset release never reads as a rise.
module sync_edge
  import pico_serial_reader_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic [STAGES:0]   fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      fill  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      fill  <= {fill[STAGES-1:0], 1'b1};
      level <= chain[STAGES-1];
      rise  <= fill[STAGES] & chain[STAGES-1] & ~level;
      fall  <= fill[STAGES] & ~chain[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/pico_serial_reader.sv
// Receives MSB-first bytes from the RP2040 frame/data/strobe link.
// State | meaning: IDLE | waiting for frame rise; SHIFT | frame open, strobes shift in data bits.
module pico_serial_reader
  import pico_serial_reader_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_in,
  input  logic                      data_in,
  input  logic                      strobe_in,
  output logic [PICO_BYTE_BITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      frame_error,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    byte_count
);

  localparam int BIT_W = $clog2(PICO_BYTE_BITS);

  logic frame_level_unused, frame_rise, frame_fall;
  logic strobe_level_unused, strobe_rise, strobe_fall_unused;
  logic data_level, data_rise_unused, data_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clk(clk), .rst_n(rst_n), .din(frame_in),
    .level(frame_level_unused), .rise(frame_rise), .fall(frame_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk(clk), .rst_n(rst_n), .din(strobe_in),
    .level(strobe_level_unused), .rise(strobe_rise), .fall(strobe_fall_unused)
  );

  // Same depth as the strobe path so the sampled bit lines up with its edge.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .din(data_in),
    .level(data_level), .rise(data_rise_unused), .fall(data_fall_unused)
  );

  state_t                    state, state_n;
  logic [BIT_W-1:0]          bit_cnt, bit_cnt_n;
  logic [PICO_BYTE_BITS-1:0] shift, shift_n, data_out_n;
  logic [COUNT_WIDTH-1:0]    byte_count_n;
  logic                      valid_n, error_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      byte_count  <= '0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      data_out    <= data_out_n;
      data_valid  <= valid_n;
      frame_error <= error_n;
      busy        <= (state_n == ST_SHIFT);
      byte_count  <= byte_count_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    data_out_n   = data_out;
    byte_count_n = byte_count;
    valid_n      = 1'b0;
    error_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_rise) begin
          state_n      = ST_SHIFT;
          bit_cnt_n    = '0;
          shift_n      = '0;
          byte_count_n = '0;
        end
      end
      ST_SHIFT: begin
        // Frame fall takes priority over a coincident strobe edge.
        if (frame_fall) begin
          state_n   = ST_IDLE;
          error_n   = (bit_cnt != '0);
          bit_cnt_n = '0;
          shift_n   = '0;
        end else if (strobe_rise) begin
          shift_n = {shift[PICO_BYTE_BITS-2:0], data_level};
          if (bit_cnt == BIT_W'(PICO_BYTE_BITS - 1)) begin
            data_out_n   = shift_n;
            valid_n      = 1'b1;
            bit_cnt_n    = '0;
            byte_count_n = byte_count + COUNT_WIDTH'(1);
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pico_serial_reader.sv
// Directed bench for pico_serial_reader; a second instance with a 2-bit byte counter shares the pins.
module tb_pico_serial_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_in = 1'b0;
  logic data_in = 1'b0;
  logic strobe_in = 1'b0;

  logic [7:0] data_out, data_out_w;
  logic       data_valid, frame_error, busy;
  logic       data_valid_w, frame_error_w, busy_w;
  logic [7:0] byte_count;
  logic [1:0] byte_count_w;

  pico_serial_reader #(.SYNC_STAGES(2), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .data_in(data_in), .strobe_in(strobe_in),
    .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
    .busy(busy), .byte_count(byte_count)
  );

  pico_serial_reader #(.SYNC_STAGES(2), .COUNT_WIDTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .data_in(data_in), .strobe_in(strobe_in),
    .data_out(data_out_w), .data_valid(data_valid_w), .frame_error(frame_error_w),
    .busy(busy_w), .byte_count(byte_count_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      got_q.push_back(data_out);
    end
    if (frame_error) err_cnt++;
    if (data_valid && frame_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    step(1);
    strobe_in = 1'b1;
    step(2);
    strobe_in = 1'b0;
    step(2);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic frame_start();
    frame_in = 1'b1;
    step(6);
  endtask

  task automatic frame_end();
    step(1);
    frame_in = 1'b0;
    step(6);
  endtask

  initial begin
    int v0, e0, q0;
    logic [7:0] a5;
    logic [7:0] burst [3];
    burst[0] = 8'h00;
    burst[1] = 8'hFF;
    burst[2] = 8'h3C;
    a5 = 8'hA5;

    // Reset held while every pin toggles
    for (int i = 0; i < 6; i++) begin
      frame_in  = i[0];
      data_in   = i[1];
      strobe_in = ~i[0];
      step(1);
      check("reset_hold", {data_out, data_valid, frame_error, busy, byte_count}, 32'h0);
      check("reset_hold_w", {data_out_w, data_valid_w, frame_error_w, busy_w, byte_count_w}, 32'h0);
    end
    frame_in = 1'b1;
    data_in = 1'b0;
    strobe_in = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(10);
    check("level_frame_no_start", busy, 1'b0);
    frame_in = 1'b0;
    step(6);

    // Single byte 0xA5 with exact latency
    frame_start();
    check("busy_in_frame", busy, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(a5[i]);
    data_in = a5[0];
    step(1);
    strobe_in = 1'b1;
    step(3);
    check("a5_not_yet_valid", data_valid, 1'b0);
    step(1);
    check("a5_valid_at_4", data_valid, 1'b1);
    check("a5_data", data_out, 8'hA5);
    step(1);
    check("a5_valid_one_cycle", data_valid, 1'b0);
    strobe_in = 1'b0;
    step(2);
    frame_end();
    check("a5_valid_count", valid_cnt, 1);
    check("a5_no_error", err_cnt, 0);
    check("a5_byte_count", byte_count, 8'd1);
    check("a5_byte_count_w", byte_count_w, 2'd1);
    check("a5_busy_after", busy, 1'b0);

    // Burst of three bytes
    v0 = valid_cnt;
    q0 = got_q.size();
    frame_start();
    for (int i = 0; i < 3; i++) send_byte(burst[i]);
    frame_end();
    check("burst_valid_count", valid_cnt - v0, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("burst_byte%0d", i), (got_q.size() > q0 + i) ? got_q[q0 + i] : 8'hxx, burst[i]);
    check("burst_byte_count", byte_count, 8'd3);
    check("burst_byte_count_w", byte_count_w, 2'd3);
    check("burst_no_error", err_cnt, 0);

    // Abort after 5 bits, then a clean 0x81 frame
    v0 = valid_cnt;
    frame_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    frame_end();
    check("abort_error", err_cnt, 1);
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_data_kept", data_out, 8'h3C);
    check("abort_byte_count", byte_count, 8'd0);
    frame_start();
    send_byte(8'h81);
    frame_end();
    check("after_abort_data", data_out, 8'h81);
    check("after_abort_valid", valid_cnt - v0, 1);
    check("after_abort_no_error", err_cnt, 1);

    // Strobe rise coincides with frame fall after 7 bits
    v0 = valid_cnt;
    e0 = err_cnt;
    frame_start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    data_in = 1'b1;
    step(1);
    strobe_in = 1'b1;
    frame_in = 1'b0;
    step(2);
    strobe_in = 1'b0;
    step(6);
    check("collide_fall_error", err_cnt - e0, 1);
    check("collide_fall_no_valid", valid_cnt - v0, 0);
    check("collide_fall_data", data_out, 8'h81);
    check("collide_fall_idle", busy, 1'b0);

    // Strobes while idle
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h55);
    check("idle_strobe_no_valid", valid_cnt - v0, 0);
    check("idle_strobe_no_error", err_cnt - e0, 0);
    check("idle_strobe_busy", busy, 1'b0);

    // Strobe rise coincides with frame rise: that strobe is ignored
    data_in = 1'b1;
    step(1);
    frame_in = 1'b1;
    strobe_in = 1'b1;
    step(2);
    strobe_in = 1'b0;
    step(4);
    send_byte(8'h42);
    frame_end();
    check("collide_rise_data", data_out, 8'h42);
    check("collide_rise_valid", valid_cnt - v0, 1);
    check("collide_rise_no_error", err_cnt - e0, 0);

    // Counter wrap on the 2-bit instance
    frame_start();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    frame_end();
    check("wrap_count8", byte_count, 8'd5);
    check("wrap_count2", byte_count_w, 2'd1);
    check("wrap_data", data_out, 8'h05);

    // Reset in the middle of a byte
    v0 = valid_cnt;
    e0 = err_cnt;
    frame_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    step(1);
    check("midreset_outputs", {data_out, data_valid, frame_error, busy, byte_count}, 32'h0);
    check("midreset_outputs_w", {data_out_w, data_valid_w, frame_error_w, busy_w, byte_count_w}, 32'h0);
    step(3);
    rst_n = 1'b1;
    step(10);
    check("midreset_no_valid", valid_cnt - v0, 0);
    check("midreset_no_error", err_cnt - e0, 0);
    check("midreset_idle", busy, 1'b0);
    frame_in = 1'b0;
    step(4);

    check("valid_error_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
